// File: rtl/nexys_starship_play_ctrl_if.sv
// Game-side signal bundle for the starship play controller.
// Every signal is sampled or updated on the rising Clk edge. There is no valid/ready pair.
// The game-state levels are inputs. Each Btn* is a debounced one-cycle repair pulse.
// The outputs are registered levels that are always valid.
interface nexys_starship_play_ctrl_if;
  logic        q_Play;
  logic        q_GameOver;
  logic        BtnL;
  logic        BtnR;
  logic        BtnD;
  logic        game_over;
  logic [2:0]  alarm;
  logic [15:0] game_time;
  logic [7:0]  score;

  modport master (
    output q_Play, q_GameOver, BtnL, BtnR, BtnD,
    input  game_over, alarm, game_time, score
  );

  modport slave (
    input  q_Play, q_GameOver, BtnL, BtnR, BtnD,
    output game_over, alarm, game_time, score
  );
endinterface

// File: rtl/nexys_starship_play_ctrl.sv
// Play-phase controller. It spawns alarms on three terminals, tracks repair deadlines,
// keeps the BCD game clock and the score, and flags game over when a deadline expires.
module nexys_starship_play_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned SPAWN_SEC     = 3,
  parameter int unsigned DEADLINE_SEC  = 5
) (
  input  logic                             Clk,
  input  logic                             Reset,
  nexys_starship_play_ctrl_if.slave        bus,
  output logic [1:0]                       dbg_state_o,  // 0 IDLE, 1 RUN, 2 DONE
  output logic [7:0]                       dbg_lfsr_o
);

  localparam int unsigned      TW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0]    TICK_MAX   = TW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]       SPAWN_INIT = 4'(SPAWN_SEC);
  localparam logic [2:0]       DL_INIT    = 3'(DEADLINE_SEC);
  localparam logic [7:0]       LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      spawn_q, spawn_d;
  logic [2:0][2:0] dl_q, dl_d;
  logic [2:0]      alarm_q, alarm_d;
  logic [15:0]     time_q, time_d;
  logic [7:0]      score_q, score_d;
  logic            go_q, go_d;
  logic [7:0]      lfsr_q, lfsr_d;

  logic            sec_pulse;
  logic [2:0]      btn;
  logic [2:0]      repair;
  logic [2:0]      expire;
  logic [2:0]      spawn_hot;
  logic [1:0]      n_rep;
  logic [8:0]      score_sum;

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    logic        carry;
    r     = t;
    carry = 1'b1;
    if (t != 16'h9999) begin
      for (int k = 0; k < 4; k++) begin
        if (carry) begin
          if (r[4*k +: 4] == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = r[4*k +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Taps 8,6,5,4 give a maximal-length sequence. The zero guard is there only for robustness.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (lfsr_q == 8'h00) lfsr_d = LFSR_SEED;
  end

  always_comb begin
    btn       = {bus.BtnD, bus.BtnR, bus.BtnL};
    sec_pulse = (state_q == S_RUN) && (tick_q == TICK_MAX);
    repair    = btn & alarm_q;
    n_rep     = 2'(repair[0]) + 2'(repair[1]) + 2'(repair[2]);
    score_sum = {1'b0, score_q} + 9'(n_rep);
    expire    = '0;
    for (int i = 0; i < 3; i++) begin
      expire[i] = sec_pulse && alarm_q[i] && (dl_q[i] == 3'd1) && !repair[i];
    end
    // The target comes from the pre-repair alarm vector, so a repaired terminal is never respawned.
    spawn_hot = '0;
    case (lfsr_q[1:0])
      2'd0:    spawn_hot = 3'b001 & ~alarm_q;
      2'd1:    spawn_hot = 3'b010 & ~alarm_q;
      2'd2:    spawn_hot = 3'b100 & ~alarm_q;
      default: begin
        if (!alarm_q[0])      spawn_hot = 3'b001;
        else if (!alarm_q[1]) spawn_hot = 3'b010;
        else if (!alarm_q[2]) spawn_hot = 3'b100;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    spawn_d = spawn_q;
    dl_d    = dl_q;
    alarm_d = alarm_q;
    time_d  = time_q;
    score_d = score_q;
    go_d    = go_q;
    case (state_q)
      S_IDLE: begin
        if (bus.q_Play) begin
          state_d = S_RUN;
          tick_d  = '0;
          spawn_d = SPAWN_INIT;
          dl_d    = '0;
          alarm_d = '0;
          time_d  = '0;
          score_d = '0;
        end
      end
      S_RUN: begin
        // An expiry always ends the game. Leaving play without one freezes everything.
        if ((|expire) || bus.q_Play) begin
          tick_d  = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
          score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
          if (sec_pulse) time_d = bcd_inc(time_q);
          for (int i = 0; i < 3; i++) begin
            if (repair[i]) begin
              alarm_d[i] = 1'b0;
              dl_d[i]    = '0;
            end else if (alarm_q[i] && sec_pulse) begin
              dl_d[i] = dl_q[i] - 3'd1;
            end
          end
          if (sec_pulse) begin
            if (spawn_q == 4'd1) begin
              spawn_d = SPAWN_INIT;
              for (int i = 0; i < 3; i++) begin
                if (spawn_hot[i]) begin
                  alarm_d[i] = 1'b1;
                  dl_d[i]    = DL_INIT;
                end
              end
            end else begin
              spawn_d = spawn_q - 4'd1;
            end
          end
          if (|expire) begin
            go_d    = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!bus.q_Play && !bus.q_GameOver) begin
          state_d = S_IDLE;
          go_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      spawn_q <= '0;
      dl_q    <= '0;
      alarm_q <= '0;
      time_q  <= '0;
      score_q <= '0;
      go_q    <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      spawn_q <= spawn_d;
      dl_q    <= dl_d;
      alarm_q <= alarm_d;
      time_q  <= time_d;
      score_q <= score_d;
      go_q    <= go_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.game_over = go_q;
  assign bus.alarm     = alarm_q;
  assign bus.game_time = time_q;
  assign bus.score     = score_q;
  assign dbg_state_o   = state_q;
  assign dbg_lfsr_o    = lfsr_q;

endmodule

// File: tb/tb_nexys_starship_play_ctrl.sv
// Bench for nexys_starship_play_ctrl. It applies a constant vector table, hand sequences
// and random play, and compares every cycle against an integer game model.
module tb_nexys_starship_play_ctrl;
  localparam int TPS = 4;
  localparam int SPN = 2;
  localparam int DLS = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       Clk;
  logic       Reset;
  logic [1:0] dbg_state;
  logic [7:0] dbg_lfsr;

  nexys_starship_play_ctrl_if ifc();

  nexys_starship_play_ctrl #(
    .TICKS_PER_SEC(TPS),
    .SPAWN_SEC    (SPN),
    .DEADLINE_SEC (DLS)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus        (ifc.slave),
    .dbg_state_o(dbg_state),
    .dbg_lfsr_o (dbg_lfsr)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference game model
  int m_mode, m_lfsr, m_tick, m_spawn, m_secs, m_score, m_go;
  int m_dl[3];
  bit m_al[3];

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) & 255) | fb;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    r[3:0]   = 4'(s % 10);
    r[7:4]   = 4'((s / 10) % 10);
    r[11:8]  = 4'((s / 100) % 10);
    r[15:12] = 4'((s / 1000) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_lfsr = 8'hA5; m_tick = 0; m_spawn = 0;
    m_secs = 0; m_score = 0; m_go = 0;
    for (int i = 0; i < 3; i++) begin m_dl[i] = 0; m_al[i] = 0; end
  endtask

  task automatic model_step(input bit play, input bit gov, input bit [2:0] btn);
    int old_lfsr, tgt, nrep;
    bit sec, expd;
    bit rep[3];
    bit old_al[3];
    old_lfsr = m_lfsr;
    m_lfsr   = lfsr_next(m_lfsr);
    case (m_mode)
      M_IDLE: if (play) begin
        m_mode = M_RUN; m_tick = 0; m_spawn = SPN; m_secs = 0; m_score = 0;
        for (int i = 0; i < 3; i++) begin m_al[i] = 0; m_dl[i] = 0; end
      end
      M_RUN: begin
        sec = (m_tick == TPS - 1);
        expd = 0; nrep = 0;
        for (int i = 0; i < 3; i++) begin
          old_al[i] = m_al[i];
          rep[i] = btn[i] && m_al[i];
          if (rep[i]) nrep++;
          if (sec && m_al[i] && m_dl[i] == 1 && !rep[i]) expd = 1;
        end
        if (!expd && !play) begin
          m_mode = M_IDLE;
        end else begin
          m_tick = (m_tick + 1) % TPS;
          if (sec && m_secs < 9999) m_secs++;
          m_score = (m_score + nrep > 255) ? 255 : m_score + nrep;
          for (int i = 0; i < 3; i++) begin
            if (rep[i]) begin m_al[i] = 0; m_dl[i] = 0; end
            else if (m_al[i] && sec) m_dl[i]--;
          end
          if (sec) begin
            if (m_spawn == 1) begin
              m_spawn = SPN;
              tgt = old_lfsr % 4;
              if (tgt == 3) begin
                tgt = -1;
                for (int i = 2; i >= 0; i--) if (!old_al[i]) tgt = i;
              end
              if (tgt >= 0 && !old_al[tgt]) begin m_al[tgt] = 1; m_dl[tgt] = DLS; end
            end else begin
              m_spawn--;
            end
          end
          if (expd) begin m_go = 1; m_mode = M_DONE; end
        end
      end
      default: if (!play && !gov) begin m_mode = M_IDLE; m_go = 0; end
    endcase
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("game_over", 32'(ifc.game_over), 32'(m_go));
    check("alarm", 32'(ifc.alarm), 32'({m_al[2], m_al[1], m_al[0]}));
    check("game_time", 32'(ifc.game_time), 32'(to_bcd(m_secs)));
    check("score", 32'(ifc.score), 32'(m_score));
    check("state", 32'(dbg_state), 32'(m_mode));
    check("lfsr", 32'(dbg_lfsr), 32'(m_lfsr));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_game_over"}, 32'(ifc.game_over), 32'd0);
    check({tag, "_alarm"}, 32'(ifc.alarm), 32'd0);
    check({tag, "_game_time"}, 32'(ifc.game_time), 32'd0);
    check({tag, "_score"}, 32'(ifc.score), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_lfsr"}, 32'(dbg_lfsr), 32'hA5);
  endtask

  // driver
  task automatic cycle(input bit play, input bit gov, input bit [2:0] btn);
    ifc.q_Play = play;
    ifc.q_GameOver = gov;
    {ifc.BtnD, ifc.BtnR, ifc.BtnL} = btn;
    @(posedge Clk);
    model_step(play, gov, btn);
    #1;
    check_model();
  endtask

  task automatic async_reset(input string tag);
    ifc.q_Play = 0; ifc.q_GameOver = 0; {ifc.BtnD, ifc.BtnR, ifc.BtnL} = 3'b000;
    #1 Reset = 1'b1;
    #1 check_zero(tag);
    @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          play;
    bit          gov;
    bit [2:0]    btn;
    int          cycles;
    bit          go_e;
    logic [15:0] time_e;
    logic [7:0]  score_e;
    logic [1:0]  state_e;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    bit [2:0] b;
    bit       done;
    int       sc_exp, cnt;
    bit       play, gov;

    vecs[0]  = '{0, 0, 3'b100, 1,  0, 16'h0000, 8'd0, 2'd0};
    vecs[1]  = '{0, 0, 3'b001, 1,  0, 16'h0000, 8'd0, 2'd0};
    vecs[2]  = '{1, 0, 3'b000, 1,  0, 16'h0000, 8'd0, 2'd1};
    vecs[3]  = '{1, 0, 3'b001, 3,  0, 16'h0000, 8'd0, 2'd1};
    vecs[4]  = '{1, 0, 3'b000, 1,  0, 16'h0001, 8'd0, 2'd1};
    vecs[5]  = '{1, 0, 3'b000, 4,  0, 16'h0002, 8'd0, 2'd1};
    vecs[6]  = '{1, 0, 3'b000, 11, 0, 16'h0004, 8'd0, 2'd1};
    vecs[7]  = '{1, 0, 3'b000, 1,  1, 16'h0005, 8'd0, 2'd2};
    vecs[8]  = '{0, 1, 3'b000, 3,  1, 16'h0005, 8'd0, 2'd2};
    vecs[9]  = '{0, 0, 3'b000, 1,  0, 16'h0005, 8'd0, 2'd0};
    vecs[10] = '{0, 0, 3'b000, 2,  0, 16'h0005, 8'd0, 2'd0};

    Reset = 1'b1;
    ifc.q_Play = 0; ifc.q_GameOver = 0;
    ifc.BtnL = 0; ifc.BtnR = 0; ifc.BtnD = 0;
    repeat (2) @(posedge Clk);
    #1 check_zero("reset");
    Reset = 1'b0;
    model_reset();

    // Ignored buttons, first spawn and expiry timing, and the DONE exit handshake.
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < vecs[r].cycles; c++) cycle(vecs[r].play, vecs[r].gov, vecs[r].btn);
      check($sformatf("vec%0d_game_over", r), 32'(ifc.game_over), 32'(vecs[r].go_e));
      check($sformatf("vec%0d_game_time", r), 32'(ifc.game_time), 32'(vecs[r].time_e));
      check($sformatf("vec%0d_score", r), 32'(ifc.score), 32'(vecs[r].score_e));
      check($sformatf("vec%0d_state", r), 32'(dbg_state), 32'(vecs[r].state_e));
    end

    // Repair terminal 1 exactly on its last-second pulse.
    cycle(1, 0, 3'b000);
    done = 0;
    for (int k = 0; k < 4000 && !done; k++) begin
      b = 3'b000;
      if (m_al[0]) b[0] = 1;
      if (m_al[2]) b[2] = 1;
      if (m_mode == M_RUN && m_al[1] && m_dl[1] == 1 && m_tick == TPS - 1) begin
        b[1] = 1;
        done = 1;
        sc_exp = m_score + int'(b[0] && m_al[0]) + 1 + int'(b[2] && m_al[2]);
        if (sc_exp > 255) sc_exp = 255;
      end
      cycle(1, 0, b);
    end
    check("late_repair_reached", 32'(done), 32'd1);
    if (done) begin
      check("late_repair_alarm1", 32'(ifc.alarm[1]), 32'd0);
      check("late_repair_score", 32'(ifc.score), 32'(sc_exp));
      check("late_repair_game_over", 32'(ifc.game_over), 32'd0);
    end

    // Leaving play without an expiry returns to IDLE.
    cycle(0, 0, 3'b000);
    check("run_to_idle_state", 32'(dbg_state), 32'd0);

    // Asynchronous reset with two alarms active.
    cycle(1, 0, 3'b000);
    cnt = 0;
    for (int k = 0; k < 100 && cnt < 2; k++) begin
      cycle(1, 0, 3'b000);
      cnt = int'(m_al[0]) + int'(m_al[1]) + int'(m_al[2]);
    end
    check("two_alarms_reached", 32'(cnt >= 2), 32'd1);
    check("two_alarms_dut", 32'(ifc.alarm[0] + ifc.alarm[1] + ifc.alarm[2] >= 2), 32'd1);
    async_reset("midrun_reset");

    // Random play.
    play = 1; gov = 0;
    for (int k = 0; k < 3000; k++) begin
      if (m_mode == M_IDLE) begin
        if ($urandom_range(0, 4) == 0) play = 1;
        gov = 0;
      end else if (m_mode == M_RUN) begin
        if ($urandom_range(0, 99) == 0) play = 0;
        gov = 0;
      end else begin
        if ($urandom_range(0, 9) == 0) play = 0;
        gov = ($urandom_range(0, 1) == 1);
      end
      for (int i = 0; i < 3; i++)
        b[i] = ($urandom_range(0, 7) == 0) || (m_al[i] && $urandom_range(0, 5) == 0);
      cycle(play, gov, b);
    end

    // Long game with every alarm repaired: game time and score both saturate.
    async_reset("pre_sat_reset");
    cycle(1, 0, 3'b000);
    for (int k = 0; k < 40100; k++) begin
      cycle(1, 0, {m_al[2], m_al[1], m_al[0]});
    end
    check("sat_game_time", 32'(ifc.game_time), 32'h9999);
    check("sat_score", 32'(ifc.score), 32'd255);
    check("sat_game_over", 32'(ifc.game_over), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
